alu_to_reg_writeback: RTL and testbench
=======================================

// Module: alu_to_reg_writeback
// PURPOSE
//   Write-back buffer from the ALU/memory side back into the register file.
//   It is the return leg of the register-to-ALU operand path.
//   - Takes result beats over a valid/ready handshake.
//   - Picks the ALU result or the memory data per beat.
//   - Holds up to 2 pending writes in order.
//   - Drives the register-file write port, which can stall through rf_ready.
// PARAMETERS
//   DATA_W  32  width of ALU result, memory data and register-file data
//   ADDR_W   5  register address width; register 0 is hard-wired zero
// PORTS
//   clock       in   1       single clock, rising edge
//   reset       in   1       asynchronous, active-high
//   in_valid    in   1       upstream beat present
//   in_ready    out  1       buffer can accept a beat this cycle
//   alu_result  in   DATA_W  ALU output
//   mem_data    in   DATA_W  load data
//   mem_to_reg  in   1       1: write mem_data; 0: write alu_result
//   reg_write   in   1       beat carries a register write
//   dest_addr   in   ADDR_W  destination register
//   rf_ready    in   1       register file accepts a write this cycle
//   rf_we       out  1       write request (valid) to register file
//   rf_addr     out  ADDR_W  write address
//   rf_data     out  DATA_W  write data
//   occupancy   out  2       stored entries, 0..2
//   fwd_addr    in   ADDR_W  (WB_FORWARD_EN only) operand address to look up
//   fwd_hit     out  1       (WB_FORWARD_EN only) pending write matches fwd_addr
//   fwd_data    out  DATA_W  (WB_FORWARD_EN only) data of matching entry
// BEHAVIOUR
//   - Clock and reset: one clock. Reset is asynchronous and active-high.
//   - Storage: 2-entry in-order FIFO. States EMPTY(0), ONE(1), FULL(2), encoded in occupancy.
//   - Values after reset: occupancy=0, rf_we=0, rf_addr=0, rf_data=0, in_ready=1, fwd_hit=0.
//   - Reset mid-operation discards all pending entries. No write is issued.
//   - in_ready = (occupancy != 2). It is decoded from registered state only.
//     There is no combinational path rf_ready -> in_ready.
//   - Accept: in_valid & in_ready.
//   - Data select happens at accept time:
//     data = mem_to_reg ? mem_data : alu_result.
//   - Dropped beats: if reg_write=0 or dest_addr=0, the beat is accepted and
//     discarded. No entry is stored and occupancy is unchanged.
//   - Output: rf_we = (occupancy != 0). rf_addr and rf_data present the oldest entry.
//     They are held stable while rf_we=1 and rf_ready=0.
//   - Pop: rf_we & rf_ready. The head retires and the next entry becomes head
//     in the following cycle.
//   - Latency: a beat stored into EMPTY appears on rf_* in the next cycle (1 cycle).
//   - Transitions:
//     - EMPTY -> ONE on store.
//     - ONE -> FULL on store without pop.
//     - ONE -> EMPTY on pop without store.
//     - ONE stays ONE on store+pop.
//     - FULL -> ONE on pop. No store is possible in FULL.
//   - Order: writes retire strictly in acceptance order, including two writes to the same address.
//   - rf_addr and rf_data when rf_we=0: keep their last values. They are don't-care.
// CONFIGURATION
//   WB_FORWARD_EN defined:
//     - fwd_* ports exist.
//     - fwd_hit=1 when fwd_addr!=0 and it equals the address of any stored entry.
//     - On multiple matches, fwd_data comes from the youngest entry.
//     - Purely combinational from stored state and fwd_addr. No extra latency.
//   WB_FORWARD_EN undefined:
//     - fwd_* ports and the compare logic are absent.
//     - All other behaviour is identical.
// TESTING
//   1. reset, then in_valid=1, alu_result=0x0000_00AA, dest=3, reg_write=1, mem_to_reg=0,
//      rf_ready=1 -> next cycle rf_we=1, rf_addr=3, rf_data=0xAA; occupancy returns to 0 after pop
//   2. mem_to_reg=1, mem_data=0xDEAD_BEEF, alu_result=0x1234, dest=7 -> rf_data=0xDEADBEEF, rf_addr=7
//   3. rf_ready=0, push writes to regs 1, 2, 3 -> occupancy=2, in_ready=0, third beat stalls;
//      release rf_ready -> rf_addr order 1, 2, 3 with data intact
//   4. dest_addr=0 or reg_write=0 with in_valid=1 -> in_ready=1, rf_we stays 0, occupancy stays 0
//   5. assert reset while occupancy=2 and rf_ready=0 -> occupancy=0, rf_we=0 immediately,
//      no write is issued after reset is released
//   6. WB_FORWARD_EN: pending writes reg5=0x11 (older) and reg5=0x22 (younger), fwd_addr=5
//      -> fwd_hit=1, fwd_data=0x22; fwd_addr=0 -> fwd_hit=0

Source files
------------

// File: rtl/alu_to_reg_writeback.sv
// Two-entry in-order write-back buffer between the ALU/memory stage and the register file.
// Optional operand forwarding lookup is compiled in when WB_FORWARD_EN is defined.
module alu_to_reg_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              rf_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
`ifdef WB_FORWARD_EN
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr0;
  logic [DATA_W-1:0] r_data0;
  logic [ADDR_W-1:0] r_addr1;
  logic [DATA_W-1:0] r_data1;

  logic              w_accept;
  logic              w_store;
  logic              w_pop;
  logic [DATA_W-1:0] w_newData;

  assign in_ready  = (r_state != FULL);
  assign rf_we     = (r_state != EMPTY);
  assign rf_addr   = r_addr0;
  assign rf_data   = r_data0;
  assign occupancy = r_state;

  assign w_accept  = in_valid & in_ready;
  // Beats without a real destination are consumed but never stored.
  assign w_store   = w_accept & reg_write & (dest_addr != '0);
  assign w_pop     = rf_we & rf_ready;
  assign w_newData = mem_to_reg ? mem_data : alu_result;

  // Slot 0 is always the head, so it directly drives the register-file port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
      r_addr0 <= '0;
      r_data0 <= '0;
      r_addr1 <= '0;
      r_data1 <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_store) begin
            r_addr0 <= dest_addr;
            r_data0 <= w_newData;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_store && w_pop) begin
            r_addr0 <= dest_addr;
            r_data0 <= w_newData;
          end else if (w_store) begin
            r_addr1 <= dest_addr;
            r_data1 <= w_newData;
            r_state <= FULL;
          end else if (w_pop) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_addr0 <= r_addr1;
            r_data0 <= r_data1;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

`ifdef WB_FORWARD_EN
  logic w_hit0;
  logic w_hit1;

  // Slot 1 is younger than slot 0, so it wins when both match.
  assign w_hit0   = (r_state != EMPTY) && (r_addr0 == fwd_addr) && (fwd_addr != '0);
  assign w_hit1   = (r_state == FULL) && (r_addr1 == fwd_addr) && (fwd_addr != '0);
  assign fwd_hit  = w_hit0 | w_hit1;
  assign fwd_data = w_hit1 ? r_data1 : (w_hit0 ? r_data0 : '0);
`endif

endmodule

// File: tb/tb_alu_to_reg_writeback.sv
// Self-checking bench for alu_to_reg_writeback: a scoreboard queue of expected register-file writes
// is filled when beats are accepted and drained by a monitor on each retiring write.
module tb_alu_to_reg_writeback;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wbEntry_t;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_data;
  logic              mem_to_reg;
  logic              reg_write;
  logic [ADDR_W-1:0] dest_addr;
  logic              rf_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [1:0]        occupancy;
`ifdef WB_FORWARD_EN
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  wbEntry_t expQ[$];
  int checks = 0;
  int failures = 0;
  int pops = 0;

  alu_to_reg_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alu_result(alu_result),
    .mem_data(mem_data),
    .mem_to_reg(mem_to_reg),
    .reg_write(reg_write),
    .dest_addr(dest_addr),
    .rf_ready(rf_ready),
    .rf_we(rf_we),
    .rf_addr(rf_addr),
    .rf_data(rf_data),
`ifdef WB_FORWARD_EN
    .fwd_addr(fwd_addr),
    .fwd_hit(fwd_hit),
    .fwd_data(fwd_data),
`endif
    .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every retiring write must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && rf_we && rf_ready) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpectedWrite addr=%0d data=%h with empty scoreboard", rf_addr, rf_data);
      end else begin
        wbEntry_t e;
        e = expQ.pop_front();
        pops++;
        if (rf_addr !== e.addr || rf_data !== e.data) begin
          failures++;
          $display("[TB] FAIL writeOrder got addr=%0d data=%h expected addr=%0d data=%h",
                   rf_addr, rf_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic sendBeat(input logic rw, input logic m2r, input logic [ADDR_W-1:0] dst,
                          input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                          input bit randReady);
    int waitCycles = 0;
    bit done = 0;
    in_valid   = 1'b1;
    reg_write  = rw;
    mem_to_reg = m2r;
    dest_addr  = dst;
    alu_result = alu;
    mem_data   = mem;
    while (!done) begin
      if (randReady) rf_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (in_ready) begin
        if (rw && dst != '0) expQ.push_back('{addr: dst, data: (m2r ? mem : alu)});
        done = 1;
      end else if (++waitCycles > 50) begin
        checks++;
        failures++;
        $display("[TB] FAIL acceptTimeout in_ready=%b required=1", in_ready);
        done = 1;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    rf_ready = 1'b1;
    while ((expQ.size() != 0 || occupancy != 2'd0) && cyc < 50) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    @(negedge clock);
    checks++;
    if (expQ.size() != 0 || occupancy !== 2'd0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d occupancy=%0d required 0/0", expQ.size(), occupancy);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; alu_result = '0; mem_data = '0; mem_to_reg = 1'b0;
    reg_write = 1'b0; dest_addr = '0; rf_ready = 1'b0;
`ifdef WB_FORWARD_EN
    fwd_addr = '0;
`endif
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks += 5;
    if (occupancy !== 2'd0) begin failures++; $display("[TB] FAIL resetOcc got=%0d exp=0", occupancy); end
    if (rf_we !== 1'b0) begin failures++; $display("[TB] FAIL resetWe got=%b exp=0", rf_we); end
    if (rf_addr !== '0) begin failures++; $display("[TB] FAIL resetAddr got=%0d exp=0", rf_addr); end
    if (rf_data !== '0) begin failures++; $display("[TB] FAIL resetData got=%h exp=0", rf_data); end
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL resetReady got=%b exp=1", in_ready); end
`ifdef WB_FORWARD_EN
    checks++;
    if (fwd_hit !== 1'b0) begin failures++; $display("[TB] FAIL resetFwdHit got=%b exp=0", fwd_hit); end
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_alu_write();
    rf_ready = 1'b1;
    sendBeat(1'b1, 1'b0, 5'd3, 32'h0000_00AA, 32'h5555_5555, 1'b0);
    @(negedge clock);
    checks += 3;
    if (rf_we !== 1'b1) begin failures++; $display("[TB] FAIL aluWe got=%b exp=1", rf_we); end
    if (rf_addr !== 5'd3) begin failures++; $display("[TB] FAIL aluAddr got=%0d exp=3", rf_addr); end
    if (rf_data !== 32'h0000_00AA) begin failures++; $display("[TB] FAIL aluData got=%h exp=000000aa", rf_data); end
    @(negedge clock);
    checks++;
    if (occupancy !== 2'd0) begin failures++; $display("[TB] FAIL aluOccAfterPop got=%0d exp=0", occupancy); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_mem_select();
    rf_ready = 1'b1;
    sendBeat(1'b1, 1'b1, 5'd7, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0);
    @(negedge clock);
    checks += 2;
    if (rf_addr !== 5'd7) begin failures++; $display("[TB] FAIL memAddr got=%0d exp=7", rf_addr); end
    if (rf_data !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL memData got=%h exp=deadbeef", rf_data); end
    @(posedge clock);
    #1;
    drain();
  endtask

  task automatic test_stall_full();
    int popsBefore = pops;
    rf_ready = 1'b0;
    sendBeat(1'b1, 1'b0, 5'd1, 32'h0000_0101, 32'h0, 1'b0);
    sendBeat(1'b1, 1'b1, 5'd2, 32'h0, 32'h0000_0202, 1'b0);
    in_valid = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b0; dest_addr = 5'd3; alu_result = 32'h0000_0303;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks += 4;
      if (occupancy !== 2'd2) begin failures++; $display("[TB] FAIL fullOcc got=%0d exp=2", occupancy); end
      if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL fullReady got=%b exp=0", in_ready); end
      if (rf_addr !== 5'd1) begin failures++; $display("[TB] FAIL stallAddr got=%0d exp=1", rf_addr); end
      if (rf_data !== 32'h0000_0101) begin failures++; $display("[TB] FAIL stallData got=%h exp=00000101", rf_data); end
      @(posedge clock);
      #1;
    end
    rf_ready = 1'b1;
    sendBeat(1'b1, 1'b0, 5'd3, 32'h0000_0303, 32'h0, 1'b0);
    drain();
    checks++;
    if (pops - popsBefore !== 3) begin failures++; $display("[TB] FAIL stallPops got=%0d exp=3", pops - popsBefore); end
  endtask

  task automatic test_dropped();
    rf_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; mem_to_reg = 1'b0; alu_result = 32'hFFFF_0000 + k;
      reg_write = (k == 0) ? 1'b0 : 1'b1;
      dest_addr = (k == 0) ? 5'd9 : 5'd0;
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL dropReady[%0d] got=%b exp=1", k, in_ready); end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      @(negedge clock);
      checks += 2;
      if (rf_we !== 1'b0) begin failures++; $display("[TB] FAIL dropWe[%0d] got=%b exp=0", k, rf_we); end
      if (occupancy !== 2'd0) begin failures++; $display("[TB] FAIL dropOcc[%0d] got=%0d exp=0", k, occupancy); end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset_midop();
    rf_ready = 1'b0;
    sendBeat(1'b1, 1'b0, 5'd4, 32'h0000_0404, 32'h0, 1'b0);
    sendBeat(1'b1, 1'b0, 5'd6, 32'h0000_0606, 32'h0, 1'b0);
    #2;
    checks++;
    if (occupancy !== 2'd2) begin failures++; $display("[TB] FAIL preResetOcc got=%0d exp=2", occupancy); end
    reset = 1'b1;
    expQ.delete();
    #1;
    checks += 2;
    if (occupancy !== 2'd0) begin failures++; $display("[TB] FAIL midResetOcc got=%0d exp=0", occupancy); end
    if (rf_we !== 1'b0) begin failures++; $display("[TB] FAIL midResetWe got=%b exp=0", rf_we); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    rf_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (rf_we !== 1'b0) begin failures++; $display("[TB] FAIL postResetWe[%0d] got=%b exp=0", i, rf_we); end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_back_to_back();
    int popsBefore = pops;
    int stored = 0;
    for (int i = 0; i < 24; i++) begin
      logic rw;
      logic [ADDR_W-1:0] dst;
      rw  = ($urandom_range(0, 7) != 0);
      dst = (i % 5 == 2) ? 5'd10 : ADDR_W'($urandom_range(0, 31));
      if (rw && dst != '0) stored++;
      sendBeat(rw, 1'($urandom_range(0, 1)), dst, $urandom, $urandom, 1'b1);
    end
    drain();
    checks++;
    if (pops - popsBefore !== stored) begin
      failures++;
      $display("[TB] FAIL b2bPops got=%0d exp=%0d", pops - popsBefore, stored);
    end
  endtask

`ifdef WB_FORWARD_EN
  task automatic test_forward();
    rf_ready = 1'b0;
    sendBeat(1'b1, 1'b0, 5'd5, 32'h0000_0011, 32'h0, 1'b0);
    sendBeat(1'b1, 1'b0, 5'd5, 32'h0000_0022, 32'h0, 1'b0);
    fwd_addr = 5'd5;
    #1;
    checks += 2;
    if (fwd_hit !== 1'b1) begin failures++; $display("[TB] FAIL fwdHit got=%b exp=1", fwd_hit); end
    if (fwd_data !== 32'h0000_0022) begin failures++; $display("[TB] FAIL fwdData got=%h exp=00000022", fwd_data); end
    fwd_addr = 5'd0;
    #1;
    checks++;
    if (fwd_hit !== 1'b0) begin failures++; $display("[TB] FAIL fwdZero got=%b exp=0", fwd_hit); end
    fwd_addr = 5'd12;
    #1;
    checks++;
    if (fwd_hit !== 1'b0) begin failures++; $display("[TB] FAIL fwdMiss got=%b exp=0", fwd_hit); end
    @(posedge clock);
    #1;
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_alu_write();
    test_mem_select();
    test_stall_full();
    test_dropped();
    test_reset_midop();
    test_back_to_back();
`ifdef WB_FORWARD_EN
    test_forward();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
